// File: rtl/conv_mem_responder.sv
// conv_mem_responder: memory-side responder for the CONV engine.
// Holds the image ROM and the five layer banks, runs the ready/busy start
// handshake, and gives a host preload/readback access while CONV is idle.
module conv_mem_responder #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int L1_DEPTH = 1024,
  parameter int L2_DEPTH = 2048,
  parameter int TIMEOUT  = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          host_we,
  input  logic          host_rd,
  input  logic [2:0]    host_sel,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  output logic [2:0]    wr_seen,
  output logic          timeout
);

  localparam int IMG_DEPTH = 1 << AW;
  localparam int L1AW      = $clog2(L1_DEPTH);
  localparam int L2AW      = $clog2(L2_DEPTH);
  localparam int CW        = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   L1_LIM   = (AW + 1)'(L1_DEPTH);
  localparam logic [AW:0]   L2_LIM   = (AW + 1)'(L2_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cycleCnt_q, cycleCnt_d;
  logic [2:0]    wrSeen_q, wrSeen_d;
  logic          timeout_q, timeout_d;

  logic [DW-1:0] idata_q;
  logic [DW-1:0] cdataRd_q;
  logic [DW-1:0] hostRdata_q;
  logic          hostRvalid_q;

  logic [DW-1:0] imgMem  [IMG_DEPTH];
  logic [DW-1:0] l0k0Mem [IMG_DEPTH];
  logic [DW-1:0] l0k1Mem [IMG_DEPTH];
  logic [DW-1:0] l1k0Mem [L1_DEPTH];
  logic [DW-1:0] l1k1Mem [L1_DEPTH];
  logic [DW-1:0] l2Mem   [L2_DEPTH];

  logic          engineActive;
  logic          hostEn;
  logic          wrHit;
  logic [2:0]    wrBit;
  logic [DW-1:0] hostWord;

  // Look up one word of a layer bank; unmapped selects and addresses past
  // the end of a short bank read back as zero.
  function automatic logic [DW-1:0] bankRead(input logic [2:0] sel,
                                             input logic [AW-1:0] addr);
    logic [DW-1:0] word;
    word = '0;
    case (sel)
      3'd1: word = l0k0Mem[addr];
      3'd2: word = l0k1Mem[addr];
      3'd3: if ({1'b0, addr} < L1_LIM) word = l1k0Mem[addr[L1AW-1:0]];
      3'd4: if ({1'b0, addr} < L1_LIM) word = l1k1Mem[addr[L1AW-1:0]];
      3'd5: if ({1'b0, addr} < L2_LIM) word = l2Mem[addr[L2AW-1:0]];
      default: word = '0;
    endcase
    return word;
  endfunction

  assign engineActive = (state_q == ARM) || (state_q == RUN);
  assign hostEn       = (state_q == IDLE) || (state_q == DONE);
  assign hostWord     = (host_sel == 3'd0) ? imgMem[host_addr]
                                           : bankRead(host_sel, host_addr);

  // Qualify a CONV layer write: only in RUN, only to a mapped bank and an
  // address inside that bank; also pick which wr_seen bit it marks.
  always_comb begin
    wrHit = 1'b0;
    wrBit = 3'b000;
    if ((state_q == RUN) && cwr) begin
      case (csel)
        3'd1, 3'd2: begin
          wrHit = 1'b1;
          wrBit = 3'b001;
        end
        3'd3, 3'd4: begin
          wrHit = ({1'b0, caddr_wr} < L1_LIM);
          wrBit = 3'b010;
        end
        3'd5: begin
          wrHit = ({1'b0, caddr_wr} < L2_LIM);
          wrBit = 3'b100;
        end
        default: begin
          wrHit = 1'b0;
          wrBit = 3'b000;
        end
      endcase
    end
  end

  // Run-control next state: start handshake, run/done sequencing, and the
  // watchdog that abandons a run that sits in ARM or RUN for too long.
  always_comb begin
    state_d    = state_q;
    cycleCnt_d = cycleCnt_q;
    wrSeen_d   = wrSeen_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARM;
          cycleCnt_d = '0;
          wrSeen_d   = 3'b000;
        end
      end
      ARM, RUN: begin
        if (cycleCnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cycleCnt_d = cycleCnt_q + CW'(1);
          if ((state_q == ARM) && busy) begin
            state_d = RUN;
          end else if ((state_q == RUN) && !busy) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (wrHit) begin
      wrSeen_d = wrSeen_d | wrBit;
    end
  end

  // Run-control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cycleCnt_q <= '0;
      wrSeen_q   <= 3'b000;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_d;
      wrSeen_q   <= wrSeen_d;
      timeout_q  <= timeout_d;
    end
  end

  // Registered read ports: the image follows iaddr only while CONV owns the
  // memories, the layer read holds between strobes, and the host read
  // reports validity one cycle after its strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idata_q      <= '0;
      cdataRd_q    <= '0;
      hostRdata_q  <= '0;
      hostRvalid_q <= 1'b0;
    end else begin
      idata_q      <= engineActive ? imgMem[iaddr] : '0;
      hostRvalid_q <= hostEn && host_rd;
      if ((state_q == RUN) && crd) begin
        cdataRd_q <= bankRead(csel, caddr_rd);
      end
      if (hostEn && host_rd) begin
        hostRdata_q <= hostWord;
      end
    end
  end

  // Memory write ports; the arrays keep their contents across reset, and a
  // read in the same cycle as a write to that word sees the old value.
  always_ff @(posedge clk) begin
    if (hostEn && host_we) begin
      imgMem[host_addr] <= host_wdata;
    end
    if (wrHit) begin
      case (csel)
        3'd1: l0k0Mem[caddr_wr] <= cdata_wr;
        3'd2: l0k1Mem[caddr_wr] <= cdata_wr;
        3'd3: l1k0Mem[caddr_wr[L1AW-1:0]] <= cdata_wr;
        3'd4: l1k1Mem[caddr_wr[L1AW-1:0]] <= cdata_wr;
        3'd5: l2Mem[caddr_wr[L2AW-1:0]] <= cdata_wr;
        default: ;
      endcase
    end
  end

  assign ready       = (state_q == ARM);
  assign done        = (state_q == DONE);
  assign wr_seen     = wrSeen_q;
  assign timeout     = timeout_q;
  assign idata       = idata_q;
  assign cdata_rd    = cdataRd_q;
  assign host_rdata  = hostRdata_q;
  assign host_rvalid = hostRvalid_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// tb_conv_mem_responder: directed bench for conv_mem_responder with a
// behavioural reference model compared against the main DUT every cycle,
// plus a second short-watchdog instance for the timeout path.
module tb_conv_mem_responder;

  localparam int DW       = 20;
  localparam int AW       = 12;
  localparam int MAIN_TO  = 1000;
  localparam int SHORT_TO = 16;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          start      = 1'b0;
  logic          host_we    = 1'b0;
  logic          host_rd    = 1'b0;
  logic [2:0]    host_sel   = '0;
  logic [AW-1:0] host_addr  = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          busy       = 1'b0;
  logic [AW-1:0] iaddr      = '0;
  logic          cwr        = 1'b0;
  logic [AW-1:0] caddr_wr   = '0;
  logic [DW-1:0] cdata_wr   = '0;
  logic          crd        = 1'b0;
  logic [AW-1:0] caddr_rd   = '0;
  logic [2:0]    csel       = '0;

  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          ready;
  logic [DW-1:0] idata;
  logic [DW-1:0] cdata_rd;
  logic          done;
  logic [2:0]    wr_seen;
  logic          timeout;

  logic          toStart = 1'b0;
  logic          tieBit  = 1'b0;
  logic [2:0]    tie3    = '0;
  logic [AW-1:0] tieA    = '0;
  logic [DW-1:0] tieD    = '0;
  logic [DW-1:0] toHostRdata;
  logic          toHostRvalid;
  logic          toReady;
  logic [DW-1:0] toIdata;
  logic [DW-1:0] toCdataRd;
  logic          toDone;
  logic [2:0]    toWrSeen;
  logic          toTimeout;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  conv_mem_responder #(.DW(DW), .AW(AW), .L1_DEPTH(1024), .L2_DEPTH(2048),
                       .TIMEOUT(MAIN_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .host_we(host_we),
    .host_rd(host_rd), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .ready(ready), .busy(busy), .iaddr(iaddr),
    .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .done(done), .wr_seen(wr_seen), .timeout(timeout)
  );

  conv_mem_responder #(.DW(DW), .AW(AW), .L1_DEPTH(1024), .L2_DEPTH(2048),
                       .TIMEOUT(SHORT_TO)) dutTo (
    .clk(clk), .reset(reset), .start(toStart), .host_we(tieBit),
    .host_rd(tieBit), .host_sel(tie3), .host_addr(tieA),
    .host_wdata(tieD), .host_rdata(toHostRdata),
    .host_rvalid(toHostRvalid), .ready(toReady), .busy(tieBit),
    .iaddr(tieA), .idata(toIdata), .cwr(tieBit), .caddr_wr(tieA),
    .cdata_wr(tieD), .crd(tieBit), .caddr_rd(tieA), .cdata_rd(toCdataRd),
    .csel(tie3), .done(toDone), .wr_seen(toWrSeen), .timeout(toTimeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Advance n clock edges; returns 1 time unit after the last edge.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model state.
  int            mode         = M_IDLE;
  int            activeCycles = 0;
  logic [DW-1:0] mImg  [4096];
  logic [DW-1:0] mBank [1:5][4096];
  logic [DW-1:0] eIdata   = '0;
  logic [DW-1:0] eCdata   = '0;
  logic [DW-1:0] eHrdata  = '0;
  logic          eHrvalid = 1'b0;
  logic          eTimeout = 1'b0;
  logic [2:0]    eWrSeen  = '0;

  function automatic int bankDepth(input int sel);
    case (sel)
      1, 2:    return 4096;
      3, 4:    return 1024;
      5:       return 2048;
      default: return 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] mRead(input int sel, input int addr);
    if (addr < bankDepth(sel)) return mBank[sel][addr];
    return '0;
  endfunction

  // Model: evaluate one clock edge from the inputs and the model's own state.
  initial forever begin
    bit active;
    bit hostOk;
    int c;
    @(posedge clk or negedge reset);
    if (!reset) begin
      mode         = M_IDLE;
      activeCycles = 0;
      eIdata       = '0;
      eCdata       = '0;
      eHrdata      = '0;
      eHrvalid     = 1'b0;
      eTimeout     = 1'b0;
      eWrSeen      = '0;
    end else begin
      active   = (mode == M_ARM) || (mode == M_RUN);
      hostOk   = (mode == M_IDLE) || (mode == M_DONE);
      c        = int'(csel);
      eIdata   = active ? mImg[iaddr] : '0;
      if ((mode == M_RUN) && crd) eCdata = mRead(c, int'(caddr_rd));
      eHrvalid = hostOk && host_rd;
      if (eHrvalid) begin
        eHrdata = (host_sel == 3'd0) ? mImg[host_addr]
                                     : mRead(int'(host_sel), int'(host_addr));
      end
      if (hostOk && host_we) mImg[host_addr] = host_wdata;
      if ((mode == M_RUN) && cwr && (int'(caddr_wr) < bankDepth(c))) begin
        mBank[c][caddr_wr] = cdata_wr;
        eWrSeen[(c - 1) / 2] = 1'b1;
      end
      case (mode)
        M_IDLE: begin
          if (start) begin
            mode         = M_ARM;
            activeCycles = 0;
            eWrSeen      = '0;
          end
        end
        M_ARM, M_RUN: begin
          activeCycles++;
          if (activeCycles >= MAIN_TO) begin
            eTimeout = 1'b1;
            mode     = M_IDLE;
          end else if ((mode == M_ARM) && busy) begin
            mode = M_RUN;
          end else if ((mode == M_RUN) && !busy) begin
            mode = M_DONE;
          end
        end
        default: mode = M_IDLE;
      endcase
    end
  end

  // Compare: check the main DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    checkOutput("ready", 32'(ready), 32'(mode == M_ARM));
    checkOutput("done", 32'(done), 32'(mode == M_DONE));
    checkOutput("idata", 32'(idata), 32'(eIdata));
    checkOutput("cdata_rd", 32'(cdata_rd), 32'(eCdata));
    checkOutput("wr_seen", 32'(wr_seen), 32'(eWrSeen));
    checkOutput("timeout", 32'(timeout), 32'(eTimeout));
    checkOutput("host_rvalid", 32'(host_rvalid), 32'(eHrvalid));
    if (eHrvalid) checkOutput("host_rdata", 32'(host_rdata), 32'(eHrdata));
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] conv_mem_responder bench starting");

    // Reset state
    applyStimulus(2);
    checkOutput("rst ready", 32'(ready), 0);
    checkOutput("rst done", 32'(done), 0);
    checkOutput("rst host_rvalid", 32'(host_rvalid), 0);
    checkOutput("rst wr_seen", 32'(wr_seen), 0);
    checkOutput("rst timeout", 32'(timeout), 0);
    checkOutput("rst idata", 32'(idata), 0);
    checkOutput("rst cdata_rd", 32'(cdata_rd), 0);
    checkOutput("rst host_rdata", 32'(host_rdata), 0);
    reset = 1'b1;
    applyStimulus(1);

    // Preload the image with IMG[a] = a
    host_we = 1'b1;
    for (int a = 0; a < 4096; a++) begin
      host_addr  = AW'(a);
      host_wdata = DW'(a);
      applyStimulus(1);
    end

    // Host write and read together, then a plain image readback
    host_addr  = 12'h011;
    host_wdata = 20'h00011;
    host_rd    = 1'b1;
    host_sel   = 3'd0;
    applyStimulus(1);
    host_we = 1'b0;
    checkOutput("we+rd rvalid", 32'(host_rvalid), 1);
    checkOutput("we+rd rdata", 32'(host_rdata), 32'h00011);
    host_addr = 12'h0AB;
    applyStimulus(1);
    host_rd = 1'b0;
    checkOutput("host img rdata", 32'(host_rdata), 32'h000AB);
    applyStimulus(1);
    checkOutput("host rvalid drop", 32'(host_rvalid), 0);

    // Start with busy held low: stays in ARM with ready high
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("arm ready", 32'(ready), 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkOutput("arm hold ready", 32'(ready), 1);
      checkOutput("arm hold done", 32'(done), 0);
    end

    // Raise busy with an image address presented
    busy  = 1'b1;
    iaddr = 12'h123;
    applyStimulus(1);
    checkOutput("run ready low", 32'(ready), 0);
    checkOutput("idata 0x123", 32'(idata), 32'h00123);

    // Host read ignored in RUN; write to csel 7 dropped
    host_rd   = 1'b1;
    host_addr = 12'h005;
    cwr       = 1'b1;
    csel      = 3'd7;
    caddr_wr  = 12'h005;
    cdata_wr  = 20'h12345;
    applyStimulus(1);
    host_rd = 1'b0;
    cwr     = 1'b0;
    checkOutput("run host_rvalid", 32'(host_rvalid), 0);
    checkOutput("csel7 wr_seen", 32'(wr_seen), 0);

    // L1K0 write at its last word, then read back
    cwr      = 1'b1;
    csel     = 3'd3;
    caddr_wr = 12'h3FF;
    cdata_wr = 20'hABCDE;
    applyStimulus(1);
    cwr      = 1'b0;
    crd      = 1'b1;
    caddr_rd = 12'h3FF;
    applyStimulus(1);
    crd = 1'b0;
    checkOutput("L1K0 readback", 32'(cdata_rd), 32'hABCDE);
    checkOutput("L1 wr_seen", 32'(wr_seen), 32'b010);
    csel     = 3'd5;
    caddr_rd = 12'h000;
    applyStimulus(1);
    checkOutput("cdata_rd hold", 32'(cdata_rd), 32'hABCDE);

    // L1K1 out-of-range write dropped, read of same address returns zero
    cwr      = 1'b1;
    csel     = 3'd4;
    caddr_wr = 12'h400;
    cdata_wr = 20'h55555;
    applyStimulus(1);
    cwr      = 1'b0;
    crd      = 1'b1;
    caddr_rd = 12'h400;
    applyStimulus(1);
    checkOutput("L1 oob read", 32'(cdata_rd), 0);
    checkOutput("L1 oob wr_seen", 32'(wr_seen), 32'b010);

    // Read and write the same word in one cycle: old data returned
    csel     = 3'd3;
    caddr_rd = 12'h3FF;
    cwr      = 1'b1;
    caddr_wr = 12'h3FF;
    cdata_wr = 20'h11111;
    applyStimulus(1);
    cwr = 1'b0;
    checkOutput("read-first old", 32'(cdata_rd), 32'hABCDE);
    applyStimulus(1);
    crd = 1'b0;
    checkOutput("read-first new", 32'(cdata_rd), 32'h11111);

    // Two L2 writes at its last word
    cwr      = 1'b1;
    csel     = 3'd5;
    caddr_wr = 12'h7FF;
    cdata_wr = 20'h22222;
    applyStimulus(1);
    cdata_wr = 20'h33333;
    applyStimulus(1);
    cwr = 1'b0;
    checkOutput("L2 wr_seen", 32'(wr_seen), 32'b110);

    // L0K0 write at the top of its full range
    cwr      = 1'b1;
    csel     = 3'd1;
    caddr_wr = 12'hFFF;
    cdata_wr = 20'h44444;
    applyStimulus(1);
    cwr      = 1'b0;
    crd      = 1'b1;
    caddr_rd = 12'hFFF;
    applyStimulus(1);
    crd = 1'b0;
    checkOutput("L0K0 top read", 32'(cdata_rd), 32'h44444);
    checkOutput("all wr_seen", 32'(wr_seen), 32'b111);

    // Busy falls: one done pulse, then host reads back the last L2 write
    busy = 1'b0;
    applyStimulus(1);
    checkOutput("done pulse", 32'(done), 1);
    host_rd   = 1'b1;
    host_sel  = 3'd5;
    host_addr = 12'h7FF;
    applyStimulus(1);
    host_rd = 1'b0;
    checkOutput("done one cycle", 32'(done), 0);
    checkOutput("host L2 rvalid", 32'(host_rvalid), 1);
    checkOutput("host L2 rdata", 32'(host_rdata), 32'h33333);
    crd      = 1'b1;
    csel     = 3'd3;
    caddr_rd = 12'h3FF;
    applyStimulus(1);
    crd = 1'b0;
    checkOutput("idle crd ignored", 32'(cdata_rd), 32'h44444);
    checkOutput("idle rvalid low", 32'(host_rvalid), 0);

    // Short watchdog: ARM with busy low times out after SHORT_TO cycles
    toStart = 1'b1;
    applyStimulus(1);
    toStart = 1'b0;
    checkOutput("to arm ready", 32'(toReady), 1);
    for (int k = 1; k < SHORT_TO; k++) begin
      applyStimulus(1);
      checkOutput("to pre timeout", 32'(toTimeout), 0);
      checkOutput("to pre ready", 32'(toReady), 1);
    end
    applyStimulus(1);
    checkOutput("to timeout set", 32'(toTimeout), 1);
    checkOutput("to ready low", 32'(toReady), 0);
    checkOutput("to no done", 32'(toDone), 0);
    applyStimulus(1);
    checkOutput("to stays idle", 32'(toReady), 0);
    toStart = 1'b1;
    applyStimulus(1);
    toStart = 1'b0;
    checkOutput("to rearm ready", 32'(toReady), 1);
    checkOutput("to timeout sticky", 32'(toTimeout), 1);

    // New run clears wr_seen; then reset mid-RUN
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("rearm wr_seen", 32'(wr_seen), 0);
    busy  = 1'b1;
    iaddr = 12'h456;
    applyStimulus(1);
    checkOutput("idata 0x456", 32'(idata), 32'h00456);
    crd      = 1'b1;
    csel     = 3'd1;
    caddr_rd = 12'hFFF;
    applyStimulus(1);
    checkOutput("run L0K0 read", 32'(cdata_rd), 32'h44444);
    reset = 1'b0;
    #1;
    checkOutput("midrst ready", 32'(ready), 0);
    checkOutput("midrst done", 32'(done), 0);
    checkOutput("midrst idata", 32'(idata), 0);
    checkOutput("midrst cdata_rd", 32'(cdata_rd), 0);
    checkOutput("midrst host_rdata", 32'(host_rdata), 0);
    checkOutput("midrst host_rvalid", 32'(host_rvalid), 0);
    checkOutput("midrst wr_seen", 32'(wr_seen), 0);
    checkOutput("midrst timeout", 32'(timeout), 0);
    applyStimulus(1);
    reset = 1'b1;
    busy  = 1'b0;
    crd   = 1'b0;
    applyStimulus(2);
    checkOutput("post rst idle", 32'(ready), 0);

    // Image contents survive reset
    host_rd   = 1'b1;
    host_sel  = 3'd0;
    host_addr = 12'h456;
    applyStimulus(1);
    host_rd = 1'b0;
    checkOutput("img kept rdata", 32'(host_rdata), 32'h00456);
    applyStimulus(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
